// File: rtl/local_predictor.sv
// Saturating-counter branch direction predictor: one counter, trained by the
// resolved Execute-stage outcome, predicting taken from the counter MSB.
module local_predictor #(
  parameter int unsigned                COUNTER_WIDTH = 2,
  parameter logic [COUNTER_WIDTH-1:0]   RESET_STATE   = 2'b01
) (
  input  logic clk,
  input  logic reset,
  input  logic PCSrcResE,
  input  logic Enable,
  output logic PCSrcPred
);

  logic [COUNTER_WIDTH-1:0] cnt_q;
  logic [COUNTER_WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (Enable) begin
      // Saturate at all-ones / all-zeros so the counter never wraps.
      if (PCSrcResE) begin
        if (cnt_q != '1) cnt_d = cnt_q + COUNTER_WIDTH'(1);
      end else begin
        if (cnt_q != '0) cnt_d = cnt_q - COUNTER_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= RESET_STATE;
    else       cnt_q <= cnt_d;
  end

  assign PCSrcPred = cnt_q[COUNTER_WIDTH-1];

endmodule

// File: tb/tb_local_predictor.sv
// Directed bench for local_predictor: literal per-step expectations plus an
// every-cycle comparison against an integer saturating-counter model.
module tb_local_predictor;

  logic clk;
  logic reset;
  logic PCSrcResE;
  logic Enable;
  logic PCSrcPred;

  int tests_run = 0;
  int tests_failed = 0;
  int model = 1;
  bit cmp_on = 0;

  local_predictor #(.COUNTER_WIDTH(2), .RESET_STATE(2'b01)) dut (
    .clk      (clk),
    .reset    (reset),
    .PCSrcResE(PCSrcResE),
    .Enable   (Enable),
    .PCSrcPred(PCSrcPred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: integer counter in 0..3, predicts taken when value >= 2.
  always @(posedge clk or posedge reset) begin
    if (reset) model = 1;
    else if (Enable === 1'b1) begin
      if (PCSrcResE === 1'b1) model = (model + 1 > 3) ? 3 : model + 1;
      else                    model = (model - 1 < 0) ? 0 : model - 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      tests_run++;
      if (PCSrcPred !== (model >= 2)) begin
        tests_failed++;
        $display("FAIL model_cmp t=%0t: PCSrcPred=%b expected %b (model=%0d)",
                 $time, PCSrcPred, (model >= 2), model);
      end
    end
  end

  task automatic check(input string name, input logic exp);
    tests_run++;
    if (PCSrcPred !== exp) begin
      tests_failed++;
      $display("FAIL %s t=%0t: PCSrcPred=%b expected %b", name, $time, PCSrcPred, exp);
    end
  endtask

  task automatic step(input string name, input logic en, input logic res, input logic exp);
    Enable = en;
    PCSrcResE = res;
    @(posedge clk);
    #1;
    check(name, exp);
  endtask

  logic [7:0] alt_pat;

  initial begin
    reset = 1'b1;
    Enable = 1'b0;
    PCSrcResE = 1'b0;
    #1;
    check("reset_held", 1'b0);
    @(posedge clk);
    #1;
    check("reset_edge", 1'b0);
    reset = 1'b0;
    cmp_on = 1;
    step("reset_init_wu", 1'b0, 1'b0, 1'b0);

    // WU -> WT, ST, ST, ST
    step("taken_0", 1'b1, 1'b1, 1'b1);
    step("taken_1", 1'b1, 1'b1, 1'b1);
    step("taken_2", 1'b1, 1'b1, 1'b1);
    step("taken_3", 1'b1, 1'b1, 1'b1);

    // ST -> WT, WU, SU, SU
    step("ntaken_0", 1'b1, 1'b0, 1'b1);
    step("ntaken_1", 1'b1, 1'b0, 1'b0);
    step("ntaken_2", 1'b1, 1'b0, 1'b0);
    step("ntaken_3", 1'b1, 1'b0, 1'b0);

    // From SU, 4T/4NT blocks: WU,WT,ST,ST then WT,WU,SU,SU (MSB index 0 first)
    alt_pat = 8'b0001_1110;
    for (int i = 0; i < 32; i++) begin
      step("alternating", 1'b1, ((i / 4) % 2) == 0, alt_pat[i % 8]);
    end

    // SU -> WU -> WT -> ST, then hold with toggling outcome
    step("to_st_0", 1'b1, 1'b1, 1'b0);
    step("to_st_1", 1'b1, 1'b1, 1'b1);
    step("to_st_2", 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 32; i++) begin
      step("hold", 1'b0, ((i / 4) % 2) == 0, 1'b1);
    end

    // Async reset from ST mid-cycle while training taken
    Enable = 1'b1;
    PCSrcResE = 1'b1;
    @(posedge clk);
    #1;
    check("pre_reset_st", 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_immediate", 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("reset_dominates", 1'b0);
    end
    #2;
    reset = 1'b0;
    Enable = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_wu", 1'b0);
    step("post_reset_train", 1'b1, 1'b1, 1'b1);
    step("post_reset_untrain", 1'b1, 1'b0, 1'b0);

    @(negedge clk);
    cmp_on = 0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/local_predictor.md
Name: local_predictor

Overview:
- Per-branch 2-bit saturating-counter direction predictor used by the pipelined RISC-V core's branch prediction unit.
- Holds one counter state and outputs a taken/not-taken prediction from the counter MSB.
- Trained by the resolved branch outcome from the Execute stage when `Enable` is asserted.
- Multiple instances can be arrayed by a global/table-based predictor. Indexing is the parent's job, not part of this block.

Parameters:
- COUNTER_WIDTH, 2, width of the saturating counter. Values other than 2 must still saturate at all-ones and all-zeros. The prediction is always the MSB.
- RESET_STATE, 2'b01 (weakly untaken), counter value loaded on reset. Must be COUNTER_WIDTH bits wide.

Ports:
- clk  input  1  system clock; state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; forces the counter to RESET_STATE.
- PCSrcResE  input  1  resolved branch outcome from the Execute stage; 1 = taken, 0 = not taken.
- Enable  input  1  training strobe; the counter updates only when high at a rising clk edge.
- PCSrcPred  output  1  predicted direction; 1 = predict taken. Equals counter MSB.

Behaviour:
- One clock; reset is asynchronous and active-high (port `reset`, clock `clk`).
- States for COUNTER_WIDTH=2: SU=00 strongly untaken, WU=01 weakly untaken, WT=10 weakly taken, ST=11 strongly taken.
- Reset:
  - While `reset`=1, the counter equals RESET_STATE (WU) immediately, independent of clk.
  - PCSrcPred=0 during and after reset.
  - Reset dominates `Enable` and `PCSrcResE`.
  - Reset asserted mid-operation from any state returns to WU asynchronously.
- Update at a rising clk edge with `reset`=0:
  - `Enable`=1 and `PCSrcResE`=1: counter increments by 1, saturating at ST (11 stays 11).
  - `Enable`=1 and `PCSrcResE`=0: counter decrements by 1, saturating at SU (00 stays 00).
  - `Enable`=0: counter holds, whatever the value of `PCSrcResE`.
- Output:
  - PCSrcPred = counter[COUNTER_WIDTH-1].
  - Purely combinational from registered state (Moore): no combinational path from any input to PCSrcPred.
  - A training update is visible on PCSrcPred after the same rising edge that applies it (one-cycle latency).
- Hysteresis:
  - From ST, two consecutive not-taken updates are needed before PCSrcPred drops to 0.
  - From SU, two consecutive taken updates are needed before PCSrcPred rises to 1.
- No X-propagation on outputs after reset: the state register is always in a defined state.
- Inputs are sampled only at the rising edge. Changes between edges have no effect except `reset`.

Test Plan:
- Reset init: `reset`=1 for one cycle, then 0, `Enable`=0, one cycle later -> PCSrcPred=0 (state WU).
- Taken training from WU: `Enable`=1, `PCSrcResE`=1 for 4 edges -> PCSrcPred sequence after each edge is 1,1,1,1 (states WT, ST, ST, ST saturate).
- Not-taken training from ST: `PCSrcResE`=0 for 4 edges -> PCSrcPred 1,0,0,0 (WT, WU, SU, SU saturate).
- Alternating blocks of 4 taken / 4 not-taken for 32 cycles with `Enable`=1 -> PCSrcPred matches MSB of a reference saturating counter every cycle.
- Hold: `Enable`=0, toggle `PCSrcResE` every 4 cycles for 32 cycles -> PCSrcPred constant at its pre-hold value.
- Async reset from ST: assert `reset` between clock edges with `Enable`=1, `PCSrcResE`=1 -> PCSrcPred=0 immediately and it stays 0 through 5 cycles of held reset.
